// File: rtl/vram_arbiter.sv
// VRAM/aux arbiter between the 6502 bus-master port and the display fetch port.
// Define VRAM_ARB_STALL_CNT_EN to build the saturating display stall counter.
module vram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] bm_addr,
    input  logic [7:0]  bm_wrdata,
    input  logic        bm_strobe,
    input  logic        bm_write,
    output logic [7:0]  bm_rddata,
    input  logic [14:0] dp_addr,
    input  logic        dp_strobe,
    output logic        dp_ack,
    output logic [31:0] dp_rddata,
    output logic        dp_rddata_valid,
    output logic [14:0] vram_addr,
    output logic [31:0] vram_wrdata,
    output logic [3:0]  vram_wrbytesel,
    output logic        vram_write,
    input  logic [31:0] vram_rddata,
    output logic [7:0]  aux_addr,
    output logic [7:0]  aux_wrdata,
    output logic        aux_strobe,
    output logic        aux_write,
    input  logic [7:0]  aux_rddata,
    output logic [15:0] dp_stall_cnt
);

    logic       w_cpu_vram;
    logic       w_cpu_aux;
    logic       w_vram_wr;
    logic [7:0] w_lane_byte;
    logic       w_unused_alias;

    logic       r_cpu_rd_pend;
    logic       r_aux_rd_pend;
    logic [1:0] r_lane;
    logic       r_dp_pend;
    logic [7:0] r_rddata_hold;

    // Request decode is gated by reset so no access leaks out while rst is high.
    assign w_cpu_vram     = !rst && bm_strobe && !bm_addr[18];
    assign w_cpu_aux      = !rst && bm_strobe &&  bm_addr[18];
    assign w_vram_wr      = w_cpu_vram && bm_write;
    assign w_unused_alias = bm_addr[17];

    assign vram_addr      = w_cpu_vram ? bm_addr[16:2] : dp_addr;
    assign vram_write     = w_vram_wr;
    assign vram_wrbytesel = w_vram_wr ? (4'b0001 << bm_addr[1:0]) : 4'b0000;
    assign vram_wrdata    = {4{bm_wrdata}};

    assign aux_addr   = bm_addr[7:0];
    assign aux_wrdata = bm_wrdata;
    assign aux_strobe = w_cpu_aux;
    assign aux_write  = w_cpu_aux && bm_write;

    // CPU VRAM access always wins; the display simply retries next cycle.
    assign dp_ack          = !rst && dp_strobe && !w_cpu_vram;
    assign dp_rddata       = vram_rddata;
    assign dp_rddata_valid = r_dp_pend;

    assign w_lane_byte = vram_rddata[{r_lane, 3'b000} +: 8];

    always_comb begin
        bm_rddata = r_rddata_hold;
        if (r_cpu_rd_pend)
            bm_rddata = w_lane_byte;
        else if (r_aux_rd_pend)
            bm_rddata = aux_rddata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_rd_pend <= 1'b0;
            r_aux_rd_pend <= 1'b0;
            r_lane        <= 2'd0;
            r_dp_pend     <= 1'b0;
            r_rddata_hold <= 8'd0;
        end else begin
            r_cpu_rd_pend <= w_cpu_vram && !bm_write;
            r_aux_rd_pend <= w_cpu_aux && !bm_write;
            r_dp_pend     <= dp_ack;
            if (w_cpu_vram && !bm_write)
                r_lane <= bm_addr[1:0];
            // Keep the last returned byte so it stays visible until the next read.
            if (r_cpu_rd_pend || r_aux_rd_pend)
                r_rddata_hold <= bm_rddata;
        end
    end

`ifdef VRAM_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= 16'd0;
        else if (dp_strobe && !dp_ack && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign dp_stall_cnt = r_stall_cnt;
`else
    assign dp_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter; one task per scenario.
module tb_vram_arbiter;

    logic        clk;
    logic        rst;
    logic [18:0] bm_addr;
    logic [7:0]  bm_wrdata;
    logic        bm_strobe;
    logic        bm_write;
    logic [7:0]  bm_rddata;
    logic [14:0] dp_addr;
    logic        dp_strobe;
    logic        dp_ack;
    logic [31:0] dp_rddata;
    logic        dp_rddata_valid;
    logic [14:0] vram_addr;
    logic [31:0] vram_wrdata;
    logic [3:0]  vram_wrbytesel;
    logic        vram_write;
    logic [31:0] vram_rddata;
    logic [7:0]  aux_addr;
    logic [7:0]  aux_wrdata;
    logic        aux_strobe;
    logic        aux_write;
    logic [7:0]  aux_rddata;
    logic [15:0] dp_stall_cnt;

    int checks = 0;
    int errors = 0;

`ifdef VRAM_ARB_STALL_CNT_EN
    localparam logic [15:0] STALL_ONE = 16'd1;
`else
    localparam logic [15:0] STALL_ONE = 16'd0;
`endif

    vram_arbiter dut (
        .clk(clk), .rst(rst),
        .bm_addr(bm_addr), .bm_wrdata(bm_wrdata), .bm_strobe(bm_strobe),
        .bm_write(bm_write), .bm_rddata(bm_rddata),
        .dp_addr(dp_addr), .dp_strobe(dp_strobe), .dp_ack(dp_ack),
        .dp_rddata(dp_rddata), .dp_rddata_valid(dp_rddata_valid),
        .vram_addr(vram_addr), .vram_wrdata(vram_wrdata),
        .vram_wrbytesel(vram_wrbytesel), .vram_write(vram_write),
        .vram_rddata(vram_rddata),
        .aux_addr(aux_addr), .aux_wrdata(aux_wrdata), .aux_strobe(aux_strobe),
        .aux_write(aux_write), .aux_rddata(aux_rddata),
        .dp_stall_cnt(dp_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here, checks follow at +1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        bm_strobe = 1'b0;
        bm_write  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bm_addr = '0; bm_wrdata = '0; bm_strobe = 1'b0; bm_write = 1'b0;
        dp_addr = 15'h0abc; dp_strobe = 1'b1; vram_rddata = 32'hFFFFFFFF; aux_rddata = 8'hFF;
        repeat (3) tick();
        #1;
        checks++; if (bm_rddata !== 8'h00) begin errors++; $display("FAIL reset_bm_rddata: got %h expected 00", bm_rddata); end
        checks++; if (dp_ack !== 1'b0) begin errors++; $display("FAIL reset_dp_ack: got %b expected 0", dp_ack); end
        checks++; if (dp_rddata_valid !== 1'b0) begin errors++; $display("FAIL reset_dp_valid: got %b expected 0", dp_rddata_valid); end
        checks++; if (dp_stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall: got %h expected 0000", dp_stall_cnt); end
        checks++; if (vram_write !== 1'b0 || aux_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobes: vram_write=%b aux_strobe=%b expected 0 0", vram_write, aux_strobe); end
        dp_strobe = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        $display("reset: done");
    endtask

    task automatic test_cpu_write();
        tick();
        bm_addr = 19'h00005; bm_wrdata = 8'hA5; bm_strobe = 1'b1; bm_write = 1'b1;
        #1;
        checks++; if (vram_addr !== 15'h0001) begin errors++; $display("FAIL wr_addr: got %h expected 0001", vram_addr); end
        checks++; if (vram_wrbytesel !== 4'b0010) begin errors++; $display("FAIL wr_bytesel: got %b expected 0010", vram_wrbytesel); end
        checks++; if (vram_wrdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr_data: got %h expected a5a5a5a5", vram_wrdata); end
        checks++; if (vram_write !== 1'b1) begin errors++; $display("FAIL wr_en: got %b expected 1", vram_write); end
        tick();
        cpu_idle();
        #1;
        checks++; if (vram_write !== 1'b0 || vram_wrbytesel !== 4'b0000) begin errors++; $display("FAIL wr_idle: write=%b bytesel=%b expected 0 0000", vram_write, vram_wrbytesel); end
        $display("cpu_write: addr=00005 data=a5");
    endtask

    task automatic test_cpu_read();
        tick();
        bm_addr = 19'h00007; bm_strobe = 1'b1; bm_write = 1'b0;
        #1;
        checks++; if (vram_addr !== 15'h0001 || vram_write !== 1'b0) begin errors++; $display("FAIL rd_issue: addr=%h write=%b expected 0001 0", vram_addr, vram_write); end
        tick();
        cpu_idle();
        vram_rddata = 32'h11223344;
        #1;
        checks++; if (bm_rddata !== 8'h11) begin errors++; $display("FAIL rd_return: got %h expected 11", bm_rddata); end
        tick();
        vram_rddata = 32'hDEADBEEF;
        repeat (3) tick();
        checks++; if (bm_rddata !== 8'h11) begin errors++; $display("FAIL rd_hold: got %h expected 11", bm_rddata); end
        // Aliased write (bit 17 set) must not disturb the held byte.
        bm_addr = 19'h20005; bm_wrdata = 8'h3C; bm_strobe = 1'b1; bm_write = 1'b1;
        #1;
        checks++; if (vram_addr !== 15'h0001 || vram_wrbytesel !== 4'b0010) begin errors++; $display("FAIL alias_wr: addr=%h bytesel=%b expected 0001 0010", vram_addr, vram_wrbytesel); end
        tick();
        cpu_idle();
        tick();
        checks++; if (bm_rddata !== 8'h11) begin errors++; $display("FAIL hold_after_wr: got %h expected 11", bm_rddata); end
        $display("cpu_read: addr=00007 data=%h", bm_rddata);
    endtask

    task automatic test_dp_block();
        tick();
        bm_addr = 19'h00010; bm_strobe = 1'b1; bm_write = 1'b0;
        dp_addr = 15'h1234; dp_strobe = 1'b1;
        #1;
        checks++; if (dp_ack !== 1'b0 || vram_addr !== 15'h0004) begin errors++; $display("FAIL blk_n: ack=%b addr=%h expected 0 0004", dp_ack, vram_addr); end
        tick();
        cpu_idle();
        vram_rddata = 32'hAABBCCDD;
        #1;
        checks++; if (dp_ack !== 1'b1 || vram_addr !== 15'h1234) begin errors++; $display("FAIL blk_n1: ack=%b addr=%h expected 1 1234", dp_ack, vram_addr); end
        checks++; if (bm_rddata !== 8'hDD || dp_rddata_valid !== 1'b0) begin errors++; $display("FAIL blk_n1_data: bm=%h valid=%b expected dd 0", bm_rddata, dp_rddata_valid); end
        tick();
        dp_strobe = 1'b0;
        vram_rddata = 32'h55667788;
        #1;
        checks++; if (dp_rddata_valid !== 1'b1 || dp_rddata !== 32'h55667788) begin errors++; $display("FAIL blk_n2: valid=%b data=%h expected 1 55667788", dp_rddata_valid, dp_rddata); end
        checks++; if (dp_ack !== 1'b0 || bm_rddata !== 8'hDD) begin errors++; $display("FAIL blk_n2_misc: ack=%b bm=%h expected 0 dd", dp_ack, bm_rddata); end
        checks++; if (dp_stall_cnt !== STALL_ONE) begin errors++; $display("FAIL blk_stall: got %h expected %h", dp_stall_cnt, STALL_ONE); end
        tick();
        checks++; if (dp_rddata_valid !== 1'b0) begin errors++; $display("FAIL blk_n3_valid: got %b expected 0", dp_rddata_valid); end
        $display("dp_block: dp_addr=1234 stall=%h", dp_stall_cnt);
    endtask

    task automatic test_aux();
        tick();
        bm_addr = 19'h40012; bm_strobe = 1'b1; bm_write = 1'b0;
        dp_addr = 15'h0777; dp_strobe = 1'b1;
        #1;
        checks++; if (aux_strobe !== 1'b1 || aux_addr !== 8'h12 || aux_write !== 1'b0) begin errors++; $display("FAIL aux_issue: strobe=%b addr=%h write=%b expected 1 12 0", aux_strobe, aux_addr, aux_write); end
        checks++; if (dp_ack !== 1'b1 || vram_addr !== 15'h0777 || vram_write !== 1'b0) begin errors++; $display("FAIL aux_dp: ack=%b addr=%h write=%b expected 1 0777 0", dp_ack, vram_addr, vram_write); end
        tick();
        cpu_idle(); dp_strobe = 1'b0;
        aux_rddata = 8'h5C;
        #1;
        checks++; if (bm_rddata !== 8'h5C || dp_rddata_valid !== 1'b1) begin errors++; $display("FAIL aux_return: bm=%h valid=%b expected 5c 1", bm_rddata, dp_rddata_valid); end
        tick();
        aux_rddata = 8'h00;
        #1;
        checks++; if (bm_rddata !== 8'h5C) begin errors++; $display("FAIL aux_hold: got %h expected 5c", bm_rddata); end
        tick();
        bm_addr = 19'h400AB; bm_wrdata = 8'h3C; bm_strobe = 1'b1; bm_write = 1'b1;
        #1;
        checks++; if (aux_write !== 1'b1 || aux_wrdata !== 8'h3C || aux_addr !== 8'hAB || vram_write !== 1'b0) begin errors++; $display("FAIL aux_write: wr=%b data=%h addr=%h vram_write=%b expected 1 3c ab 0", aux_write, aux_wrdata, aux_addr, vram_write); end
        tick();
        cpu_idle();
        checks++; if (dp_stall_cnt !== STALL_ONE) begin errors++; $display("FAIL aux_stall: got %h expected %h", dp_stall_cnt, STALL_ONE); end
        $display("aux: addr=40012 data=5c");
    endtask

    task automatic test_back_to_back();
        tick();
        bm_addr = 19'h00001; bm_strobe = 1'b1; bm_write = 1'b0;
        tick();
        bm_addr = 19'h00006;
        vram_rddata = 32'h01020304;
        #1;
        checks++; if (bm_rddata !== 8'h03 || vram_addr !== 15'h0001) begin errors++; $display("FAIL b2b_first: bm=%h addr=%h expected 03 0001", bm_rddata, vram_addr); end
        tick();
        cpu_idle();
        vram_rddata = 32'hA0B0C0D0;
        #1;
        checks++; if (bm_rddata !== 8'hB0) begin errors++; $display("FAIL b2b_second: got %h expected b0", bm_rddata); end
        tick();
        vram_rddata = 32'h0;
        #1;
        checks++; if (bm_rddata !== 8'hB0) begin errors++; $display("FAIL b2b_hold: got %h expected b0", bm_rddata); end
        $display("back_to_back: bytes 03 b0");
    endtask

    task automatic test_reset_mid();
        tick();
        bm_addr = 19'h00003; bm_strobe = 1'b1; bm_write = 1'b0;
        tick();
        cpu_idle();
        vram_rddata = 32'hFFFFFFFF;
        rst = 1'b1;
        #1;
        checks++; if (bm_rddata !== 8'h00 || dp_rddata_valid !== 1'b0) begin errors++; $display("FAIL rstmid_bm: bm=%h valid=%b expected 00 0", bm_rddata, dp_rddata_valid); end
        checks++; if (dp_stall_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_stall: got %h expected 0000", dp_stall_cnt); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bm_rddata !== 8'h00 || dp_rddata_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after: bm=%h valid=%b expected 00 0", bm_rddata, dp_rddata_valid); end
        tick();
        checks++; if (bm_rddata !== 8'h00) begin errors++; $display("FAIL rstmid_after2: got %h expected 00", bm_rddata); end
        $display("reset_mid: bm_rddata=%h", bm_rddata);
    endtask

    task automatic test_stall_count();
        // Continuous CPU VRAM writes keep the display blocked every cycle.
        tick();
        bm_addr = 19'h00000; bm_wrdata = 8'h00; bm_strobe = 1'b1; bm_write = 1'b1;
        dp_addr = 15'h0001; dp_strobe = 1'b1;
`ifdef VRAM_ARB_STALL_CNT_EN
        repeat (70000) tick();
        checks++; if (dp_stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat: got %h expected ffff", dp_stall_cnt); end
`else
        repeat (20) tick();
        checks++; if (dp_stall_cnt !== 16'h0000) begin errors++; $display("FAIL stall_off: got %h expected 0000", dp_stall_cnt); end
`endif
        checks++; if (dp_ack !== 1'b0) begin errors++; $display("FAIL stall_ack: got %b expected 0", dp_ack); end
        cpu_idle();
        #1;
        checks++; if (dp_ack !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", dp_ack); end
        tick();
        dp_strobe = 1'b0;
        $display("stall_count: dp_stall_cnt=%h", dp_stall_cnt);
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_dp_block();
        test_aux();
        test_back_to_back();
        test_reset_mid();
        test_stall_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
